// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the clock divider bank
package clk_div_pkg;
  localparam int CNT_W_DEF = 16;
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  function automatic logic [31:0] hi_len(input logic [31:0] d);
    return (d + 32'd1) >> 1;
  endfunction
endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch: one divider channel with period-boundary divisor reload
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_sync_clr,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wdata,
  input  logic [CNT_W-1:0] i_init,
  output logic [CNT_W-1:0] o_act,
  output logic             o_div,
  output logic             o_tick
);
  logic [CNT_W-1:0] r_act, r_pend, r_cnt;
  logic             r_div, r_tick;
  logic [CNT_W-1:0] w_pend_nx, w_cnt_inc, w_hi;
  logic             w_wrap;
  assign w_pend_nx = i_wr ? i_wdata : r_pend;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_hi      = CNT_W'(hi_len(32'(r_act)));
  // >= rather than == so a counter left beyond a shrunken divisor wraps at once
  assign w_wrap    = (r_act != '0) && (r_cnt >= r_act - CNT_W'(1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_act  <= i_init;
      r_pend <= i_init;
      r_cnt  <= (i_init == '0) ? '0 : i_init - CNT_W'(1);
      r_div  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_pend <= w_pend_nx;
      if (i_sync_clr || (i_en && w_wrap)) begin
        r_act  <= w_pend_nx;
        r_cnt  <= '0;
        r_tick <= w_pend_nx != '0;
        r_div  <= w_pend_nx > CNT_W'(1);
      end else if (!i_en) begin
        r_act  <= w_pend_nx;
        r_tick <= 1'b0;
      end else if (r_act == '0) begin
        r_act  <= w_pend_nx;
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_div  <= 1'b0;
      end else begin
        r_cnt  <= w_cnt_inc;
        r_tick <= 1'b0;
        r_div  <= w_cnt_inc < w_hi;
      end
    end
  assign o_act  = r_act;
  assign o_div  = r_div;
  assign o_tick = r_tick;
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH programmable clock dividers with tick strobes and readback
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int                      NUM_CH   = 4,
  parameter int                      CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {16'd1000, 16'd200, 16'd100, 16'd20},
  localparam int                     AW       = addr_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [CNT_W-1:0]  cfg_wdata,
  output logic [CNT_W-1:0]  cfg_rdata,
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] tick
);
  // padded to the full address space so unused addresses read back as 0
  logic [CNT_W-1:0] w_act [2**AW];
  genvar i;
  for (i = 0; i < 2**AW; i++) begin : g_ch
    if (i < NUM_CH) begin : g_on
      clk_div_ch #(.CNT_W(CNT_W)) u_ch (
        .clk       (clk),
        .rst       (rst),
        .i_en      (ch_en[i]),
        .i_sync_clr(sync_clr),
        .i_wr      (cfg_we && (cfg_addr == AW'(i))),
        .i_wdata   (cfg_wdata),
        .i_init    (DIV_INIT[i*CNT_W +: CNT_W]),
        .o_act     (w_act[i]),
        .o_div     (div_out[i]),
        .o_tick    (tick[i])
      );
    end else begin : g_off
      assign w_act[i] = '0;
    end
  end
  assign cfg_rdata = w_act[cfg_addr];
endmodule
